mac_feed_seq: RTL and testbench

Sequencer for the 4x4 systolic MAC array (`test`). It holds a feature tile and a weight tile in local register buffers loaded through a write port. On `start`, it drives the array's activation lanes with the diagonal skew the array requires and loads weights one column per cycle. It then flushes the array with zeros for a fixed drain period and pulses `done`.

---
 rtl/mac_feed_seq.sv | 130 +++++++++++++
 tb/tb_mac_feed_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feed_seq.sv
// Tile buffers plus skewed activation / column-wise weight feed sequencer for an NxN systolic MAC array.
// Optional feature macro MAC_FEED_STALL_EN: stall freezes sequencing and outputs in FEED/DRAIN.
module mac_feed_seq #(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DRAIN = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    input  logic                 stall,
    output logic [N*DW-1:0]      a_feed,
    output logic [N*N*DW-1:0]    w_feed,
    output logic [N-1:0]         w_col_ld,
    output logic                 acc_clr,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(2*N - 1 + DRAIN);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N - 2 + DRAIN);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     fbuf [N][N];
    logic [DW-1:0]     wbuf [N][N];
    logic              hold_c;
    logic [CW:0]       diff_c;
    logic [N*DW-1:0]   a_step_c;
    logic [N*N*DW-1:0] w_step_c;
    logic [N-1:0]      ld_step_c;

`ifdef MAC_FEED_STALL_EN
    assign hold_c = stall && (state == S_FEED || state == S_DRAIN);
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold_c       = 1'b0;
`endif

    // Feed step t = cnt: lane i takes fbuf[i][t-i] inside the diagonal window; column t of weights loads.
    always_comb begin
        a_step_c  = '0;
        w_step_c  = w_feed;
        ld_step_c = '0;
        diff_c    = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                diff_c = {1'b0, cnt} - (CW+1)'(i);
                if (!diff_c[CW] && (diff_c[CW-1:0] < CW'(N)))
                    a_step_c[i*DW +: DW] = fbuf[i][IW'(diff_c[CW-1:0])];
            end
            for (int c = 0; c < N; c++) begin
                if (cnt == CW'(c)) begin
                    ld_step_c[c] = 1'b1;
                    for (int r = 0; r < N; r++)
                        w_step_c[(r*N + c)*DW +: DW] = wbuf[r][c];
                end
            end
        end
    end

    // State, counter, buffers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_feed   <= '0;
            w_feed   <= '0;
            w_col_ld <= '0;
            acc_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    fbuf[r][c] <= '0;
                    wbuf[r][c] <= '0;
                end
            end
        end else begin
            if (state == S_IDLE && wr_en) begin
                if (wr_sel) wbuf[wr_row][wr_col] <= wr_data;
                else        fbuf[wr_row][wr_col] <= wr_data;
            end
            busy     <= (state != S_IDLE);
            done     <= 1'b0;
            acc_clr  <= 1'b0;
            w_col_ld <= '0;
            if (!hold_c) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_FEED;
                            cnt   <= '0;
                        end
                    end
                    S_FEED: begin
                        a_feed   <= a_step_c;
                        w_feed   <= w_step_c;
                        w_col_ld <= ld_step_c;
                        acc_clr  <= (cnt == '0);
                        cnt      <= cnt + CW'(1);
                        if (cnt == FEED_LAST) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        a_feed <= '0;
                        cnt    <= cnt + CW'(1);
                        if (cnt == DRAIN_LAST) begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mac_feed_seq.sv
// Scoreboard bench for mac_feed_seq: per-cycle expected outputs queued at start, popped after each edge.
module tb_mac_feed_seq;
    localparam int unsigned N        = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned DRAIN    = 3;
    localparam int unsigned WW       = N*N*DW;
    localparam int          PASS_LEN = 2*N + DRAIN + 1;

    typedef struct packed {
        logic [N*DW-1:0] a;
        logic [WW-1:0]   w;
        logic [N-1:0]    ld;
        logic            clr;
        logic            busy;
        logic            done;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic              wr_sel = 1'b0;
    logic [1:0]        wr_row = '0;
    logic [1:0]        wr_col = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [N*DW-1:0]   a_feed;
    logic [WW-1:0]     w_feed;
    logic [N-1:0]      w_col_ld;
    logic              acc_clr;
    logic              busy;
    logic              done;

    exp_t              sb [$];
    logic [DW-1:0]     fm [N][N];
    logic [DW-1:0]     wm [N][N];
    logic [N*DW-1:0]   frow [N];
    logic [WW-1:0]     w_cur;
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                seen;

    mac_feed_seq #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .start(start), .stall(stall), .a_feed(a_feed), .w_feed(w_feed),
        .w_col_ld(w_col_ld), .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},    cyc, WW'(a_feed),   '0);
        chk({tag, "_w"},    cyc, w_feed,        '0);
        chk({tag, "_ld"},   cyc, WW'(w_col_ld), '0);
        chk({tag, "_clr"},  cyc, WW'(acc_clr),  '0);
        chk({tag, "_busy"}, cyc, WW'(busy),     '0);
        chk({tag, "_done"}, cyc, WW'(done),     '0);
    endtask

    task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Expected outputs after edges E1..E12 of one pass; optional stall repeats record st_k st_n times.
    task automatic push_pass(input int st_k, input int st_n);
        exp_t e;
        int   t;
        for (int k = 1; k <= PASS_LEN; k++) begin
            e      = '0;
            t      = k - 1;
            if (k <= 2*N - 1) begin
                for (int i = 0; i < N; i++)
                    if (t - i >= 0 && t - i < N) e.a[i*DW +: DW] = fm[i][t - i];
                if (t < N) begin
                    e.ld[t] = 1'b1;
                    for (int r = 0; r < N; r++) w_cur[(r*N + t)*DW +: DW] = wm[r][t];
                end
                e.clr = (t == 0);
            end
            e.w    = w_cur;
            e.busy = (k <= PASS_LEN - 1);
            e.done = (k == PASS_LEN - 1);
            sb.push_back(e);
            if (k == st_k) begin
                for (int j = 0; j < st_n; j++) begin
                    e.ld  = '0;
                    e.clr = 1'b0;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic check_cycles(input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            tick();
            cyc++;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_underflow cyc=%0d observed=empty expected=entry", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("a_feed",   cyc, WW'(a_feed),   WW'(e.a));
                chk("w_feed",   cyc, w_feed,        e.w);
                chk("w_col_ld", cyc, WW'(w_col_ld), WW'(e.ld));
                chk("acc_clr",  cyc, WW'(acc_clr),  WW'(e.clr));
                chk("busy",     cyc, WW'(busy),     WW'(e.busy));
                chk("done",     cyc, WW'(done),     WW'(e.done));
            end
        end
    endtask

    task automatic load_tiles();
        frow[0] = {8'd4, 8'd0, 8'd2, 8'd1};
        frow[1] = {8'd4, 8'd3, 8'd2, 8'd0};
        frow[2] = {8'd4, 8'd3, 8'd0, 8'd1};
        frow[3] = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                fm[r][c] = frow[r][(N-1-c)*DW +: DW];
                wm[r][c] = DW'(c + 1);
                wr(1'b0, r, c, fm[r][c]);
                wr(1'b1, r, c, wm[r][c]);
            end
        end
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        w_cur = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("rst");
        reset = 1'b1;
        tick();

        // Pass 1: diagonal skew and column-by-column weight load.
        load_tiles();
        push_pass(0, 0);
        launch();
        check_cycles(PASS_LEN);

        // Pass 2: feature write during FEED must be dropped.
        push_pass(0, 0);
        launch();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd9;
        check_cycles(3);
        wr_en = 1'b0;
        check_cycles(PASS_LEN - 3);

        // Pass 3 with start re-raised mid-pass and held through DONE, then pass 4 after one idle edge.
        push_pass(0, 0);
        push_pass(0, 0);
        launch();
        check_cycles(3);
        start = 1'b1;
        check_cycles(PASS_LEN - 3);
        start = 1'b0;
        check_cycles(PASS_LEN);

        // Reset during step 4 clears outputs and buffers immediately.
        push_pass(0, 0);
        launch();
        check_cycles(5);
        sb.delete();
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        tick();
        reset = 1'b1;
        seen = 0;
        for (int j = 0; j < PASS_LEN; j++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("no_done_after_rst", cyc, WW'(seen), '0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                fm[r][c] = '0;
                wm[r][c] = '0;
            end
        w_cur = '0;
        push_pass(0, 0);
        launch();
        check_cycles(PASS_LEN);

        // Reload; same-cycle write and start, with a two-cycle stall at step 1.
        load_tiles();
        fm[0][0] = 8'd7;
`ifdef MAC_FEED_STALL_EN
        push_pass(2, 2);
`else
        push_pass(0, 0);
`endif
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd7;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check_cycles(2);
        stall = 1'b1;
        check_cycles(2);
        stall = 1'b0;
`ifdef MAC_FEED_STALL_EN
        check_cycles(PASS_LEN - 2);
`else
        check_cycles(PASS_LEN - 4);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
